// File: rtl/grn_pkg.sv
// Shared types for the GRN attractor-search controller.
// State encoding, width defaults and the default result bundle.
package grn_pkg;

    localparam int DEF_N_NODES = 8;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PERIOD,
        REPORT
    } state_t;

    typedef struct packed {
        logic [DEF_N_NODES-1:0] seed;
        logic [DEF_CNT_W-1:0]   steps;
        logic [DEF_CNT_W-1:0]   period;
        logic [DEF_N_NODES-1:0] state;
        logic                   timeout;
    } res_t;

endpackage

// File: rtl/grn_attractor_ctrl_if.sv
// Result port of the attractor controller: valid/ready plus payload.
// The controller is the master; the result consumer is the slave.
interface grn_attractor_ctrl_if
    import grn_pkg::*;
#(
    parameter int N_NODES = DEF_N_NODES,
    parameter int CNT_W   = DEF_CNT_W
);

    logic               out_valid;
    logic               out_ready;
    logic [N_NODES-1:0] out_seed;
    logic [CNT_W-1:0]   out_steps;
    logic [CNT_W-1:0]   out_period;
    logic [N_NODES-1:0] out_state;
    logic               out_timeout;

    modport master (
        output out_valid, out_seed, out_steps,
        output out_period, out_state, out_timeout,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_seed, out_steps,
        input  out_period, out_state, out_timeout,
        output out_ready
    );

endinterface

// File: rtl/grn_result_reg.sv
// One-entry valid/ready holding register for a result bundle.
// Data stays frozen while valid and not yet accepted.
module grn_result_reg
    import grn_pkg::*;
#(
    parameter type T = res_t
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    input  T     i_data,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data
);

    logic r_valid;
    T     r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (!r_valid || i_ready) begin
            r_valid <= i_valid;
            if (i_valid) r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/grn_attractor_ctrl.sv
// Floyd cycle-detection sweep over every initial state of a boolean
// gene-regulatory network; reports meet step count and period per seed.
module grn_attractor_ctrl
    import grn_pkg::*;
#(
    parameter int N_NODES   = DEF_N_NODES,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_STEPS = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] s0,
    input  logic [N_NODES-1:0] s1,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_state,
    output logic               busy,
    output logic               done,
    grn_attractor_ctrl_if.master res
);

    typedef struct packed {
        logic [N_NODES-1:0] seed;
        logic [CNT_W-1:0]   steps;
        logic [CNT_W-1:0]   period;
        logic [N_NODES-1:0] state;
        logic               timeout;
    } res_n_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);
    localparam logic [N_NODES:0] LAST  = {1'b0, {N_NODES{1'b1}}};

    state_t             r_state, w_next;
    logic [N_NODES:0]   r_seed, w_seed_nxt;
    logic [CNT_W-1:0]   r_steps, w_steps_nxt;
    logic [CNT_W-1:0]   r_period, w_period_nxt;
    logic [N_NODES-1:0] r_meet, w_meet_nxt;
    logic               r_loaded, w_loaded_nxt;
    logic               r_done, w_done_nxt;
    logic               w_meet, w_push, w_tmo, w_fire, w_rv;
    logic [CNT_W-1:0]   w_steps_inc, w_period_inc;
    res_n_t             w_res_in, w_res_out;

    assign w_steps_inc  = (&r_steps)  ? r_steps  : r_steps + CNT_W'(1);
    assign w_period_inc = (&r_period) ? r_period : r_period + CNT_W'(1);

    // Tortoise has m steps only after an even number 2m of hare pulses
    assign w_meet = r_loaded && !r_steps[0] && (r_steps != '0) && (s0 == s1);
    assign w_fire = w_rv && res.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_seed   <= '0;
            r_steps  <= '0;
            r_period <= '0;
            r_meet   <= '0;
            r_loaded <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_seed   <= w_seed_nxt;
            r_steps  <= w_steps_nxt;
            r_period <= w_period_nxt;
            r_meet   <= w_meet_nxt;
            r_loaded <= w_loaded_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_seed_nxt   = r_seed;
        w_steps_nxt  = r_steps;
        w_period_nxt = r_period;
        w_meet_nxt   = r_meet;
        w_loaded_nxt = r_loaded;
        w_done_nxt   = 1'b0;
        w_push       = 1'b0;
        w_tmo        = 1'b0;
        reset_nos    = 1'b0;
        start_s0     = 1'b0;
        start_s1     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_seed_nxt = '0;
                    w_next     = LOAD;
                end
            end
            LOAD: begin
                reset_nos    = 1'b1;
                w_steps_nxt  = '0;
                w_period_nxt = '0;
                w_loaded_nxt = 1'b0;
                w_next       = RUN;
            end
            RUN: begin
                w_loaded_nxt = 1'b1;
                if (w_meet) begin
                    w_meet_nxt = s0;
                    w_next     = PERIOD;
                end else if (r_steps < MAX_C) begin
                    start_s0    = 1'b1;
                    start_s1    = 1'b1;
                    w_steps_nxt = w_steps_inc;
                end else begin
                    w_tmo  = 1'b1;
                    w_push = 1'b1;
                    w_next = REPORT;
                end
            end
            PERIOD: begin
                if ((r_period == '0) || (s1 != s0)) begin
                    if (r_period < MAX_C) begin
                        start_s1     = 1'b1;
                        w_period_nxt = w_period_inc;
                    end else begin
                        w_tmo  = 1'b1;
                        w_push = 1'b1;
                        w_next = REPORT;
                    end
                end else begin
                    w_push = 1'b1;
                    w_next = REPORT;
                end
            end
            REPORT: begin
                if (w_fire) begin
                    if (r_seed == LAST) begin
                        w_done_nxt = 1'b1;
                        w_next     = IDLE;
                    end else begin
                        w_seed_nxt = r_seed + 1'b1;
                        w_next     = LOAD;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // A run-phase timeout has no latched meet state, so report live s0
    always_comb begin
        w_res_in         = '0;
        w_res_in.seed    = r_seed[N_NODES-1:0];
        w_res_in.steps   = r_steps;
        w_res_in.period  = w_tmo ? '0 : r_period;
        w_res_in.state   = (r_state == RUN) ? s0 : r_meet;
        w_res_in.timeout = w_tmo;
    end

    grn_result_reg #(.T(res_n_t)) u_res (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_push),
        .i_data  (w_res_in),
        .o_valid (w_rv),
        .i_ready (res.out_ready),
        .o_data  (w_res_out)
    );

    assign res.out_valid   = w_rv;
    assign res.out_seed    = w_res_out.seed;
    assign res.out_steps   = w_res_out.steps;
    assign res.out_period  = w_res_out.period;
    assign res.out_state   = w_res_out.state;
    assign res.out_timeout = w_res_out.timeout;

    assign init_state = r_seed[N_NODES-1:0];
    assign busy       = (r_state != IDLE);
    assign done       = r_done;

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Bench for grn_attractor_ctrl: 3-node networks with pass-gated node
// models, Floyd results predicted by iterating the network function.
module tb_grn_attractor_ctrl;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic sel   = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] tbl [8];

    logic [2:0] s0a = '0, s1a = '0, s0b = '0, s1b = '0;
    logic       pha = 1'b0, phb = 1'b0;
    logic       rnos_a, p0a, p1a, busy_a, done_a;
    logic       rnos_b, p0b, p1b, busy_b, done_b;
    logic [2:0] init_a, init_b;

    grn_attractor_ctrl_if #(.N_NODES(3), .CNT_W(16)) res_a ();
    grn_attractor_ctrl_if #(.N_NODES(3), .CNT_W(16)) res_b ();

    assign res_a.out_ready = ready & ~sel;
    assign res_b.out_ready = ready & sel;

    grn_attractor_ctrl #(.N_NODES(3), .CNT_W(16), .MAX_STEPS(4096)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel),
        .s0(s0a), .s1(s1a),
        .reset_nos(rnos_a), .start_s0(p0a), .start_s1(p1a),
        .init_state(init_a), .busy(busy_a), .done(done_a),
        .res(res_a)
    );

    grn_attractor_ctrl #(.N_NODES(3), .CNT_W(16), .MAX_STEPS(4)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel),
        .s0(s0b), .s1(s1b),
        .reset_nos(rnos_b), .start_s0(p0b), .start_s1(p1b),
        .init_state(init_b), .busy(busy_b), .done(done_b),
        .res(res_b)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] nf(input logic [2:0] x);
        return tbl[x];
    endfunction

    // Nodes: hare applies every pulse, tortoise every second pulse after a load
    always @(posedge clk) begin
        if (rnos_a) begin
            s0a <= init_a; s1a <= init_a; pha <= 1'b0;
        end else begin
            if (p1a) s1a <= nf(s1a);
            if (p0a) begin
                if (!pha) s0a <= nf(s0a);
                pha <= ~pha;
            end
        end
    end

    always @(posedge clk) begin
        if (rnos_b) begin
            s0b <= init_b; s1b <= init_b; phb <= 1'b0;
        end else begin
            if (p1b) s1b <= nf(s1b);
            if (p0b) begin
                if (!phb) s0b <= nf(s0b);
                phb <= ~phb;
            end
        end
    end

    wire        t_valid  = sel ? res_b.out_valid   : res_a.out_valid;
    wire [2:0]  t_seed   = sel ? res_b.out_seed    : res_a.out_seed;
    wire [15:0] t_steps  = sel ? res_b.out_steps   : res_a.out_steps;
    wire [15:0] t_period = sel ? res_b.out_period  : res_a.out_period;
    wire [2:0]  t_state  = sel ? res_b.out_state   : res_a.out_state;
    wire        t_tmo    = sel ? res_b.out_timeout : res_a.out_timeout;
    wire        t_rnos   = sel ? rnos_b : rnos_a;
    wire        t_p0     = sel ? p0b    : p0a;
    wire        t_p1     = sel ? p1b    : p1a;
    wire [2:0]  t_init   = sel ? init_b : init_a;
    wire        t_busy   = sel ? busy_b : busy_a;
    wire        t_done   = sel ? done_b : done_a;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] fpow(input logic [2:0] x, input int k);
        logic [2:0] y = x;
        for (int i = 0; i < k; i++) y = tbl[y];
        return y;
    endfunction

    // Smallest m with f^m(x) == f^2m(x), then smallest period of f^m(x)
    task automatic model(input int seed, input int mx, output int st,
                         output int pe, output int sv, output bit tmo);
        int  m = 0;
        int  p = 0;
        bit  hit = 0;
        logic [2:0] t;
        for (int k = 1; 2 * k <= mx && !hit; k++)
            if (fpow(3'(seed), k) == fpow(3'(seed), 2 * k)) begin
                hit = 1; m = k;
            end
        if (!hit) begin
            st = mx; pe = 0; sv = 0; tmo = 1;
            return;
        end
        t = fpow(3'(seed), m);
        st = 2 * m; sv = int'(t); tmo = 1;
        pe = 0;
        for (int q = 1; q <= mx && p == 0; q++)
            if (fpow(t, q) == t) p = q;
        if (p != 0) begin
            pe = p; tmo = 0;
        end
    endtask

    task automatic check_rst();
        check("rst_reset_nos", 32'(t_rnos), 0);
        check("rst_start_s0",  32'(t_p0), 0);
        check("rst_start_s1",  32'(t_p1), 0);
        check("rst_init",      32'(t_init), 0);
        check("rst_busy",      32'(t_busy), 0);
        check("rst_done",      32'(t_done), 0);
        check("rst_valid",     32'(t_valid), 0);
        check("rst_seed",      32'(t_seed), 0);
        check("rst_steps",     32'(t_steps), 0);
        check("rst_period",    32'(t_period), 0);
        check("rst_state",     32'(t_state), 0);
        check("rst_timeout",   32'(t_tmo), 0);
    endtask

    task automatic sweep(input int mx, input int bp_seed,
                         input int abort_seed, input bit inj);
        int e_st, e_pe, e_sv, hold, budget;
        bit e_tmo;
        bit injected = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < 8; s++) begin
            model(s, mx, e_st, e_pe, e_sv, e_tmo);
            budget = 0;
            while (!t_valid && budget < 200) begin
                if (abort_seed == s && t_rnos) begin
                    @(negedge clk);
                    rst = 1'b0;
                    @(negedge clk);
                    check_rst();
                    rst = 1'b1;
                    @(negedge clk);
                    return;
                end
                if (inj && !injected && t_busy && t_p1 && !t_p0) begin
                    start = 1'b1; injected = 1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                budget++;
            end
            start = 1'b0;
            if (!t_valid) begin
                check("valid_wait", 0, 1);
                return;
            end
            check("seed",    32'(t_seed), 32'(s));
            check("steps",   32'(t_steps), 32'(e_st));
            check("period",  32'(t_period), 32'(e_pe));
            check("timeout", 32'(t_tmo), 32'(e_tmo));
            if (!e_tmo) check("state", 32'(t_state), 32'(e_sv));
            hold = (s == bp_seed) ? 10 : int'($urandom_range(0, 3));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", 32'(t_valid), 1);
                check("hold_data", {t_seed, t_steps, t_period[12:0]},
                      {3'(s), 16'(e_st), 13'(e_pe)});
                check("hold_pulse", 32'({t_p0, t_p1, t_rnos}), 0);
            end
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            check("post_valid", 32'(t_valid), 0);
            if (s < 7) begin
                check("next_load", 32'(t_rnos), 1);
                check("next_seed", 32'(t_init), 32'(s + 1));
            end else begin
                check("done_pulse", 32'(t_done), 1);
            end
        end
        @(negedge clk);
        check("done_low", 32'(t_done), 0);
        check("idle", 32'(t_busy), 0);
    endtask

    task automatic set_rotate();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            tbl[i] = {v[1:0], v[2]};
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = 3'(i);
        repeat (3) @(negedge clk);
        check_rst();
        rst = 1'b1;
        @(negedge clk);

        sweep(4096, 3, -1, 0);

        set_rotate();
        sweep(4096, -1, -1, 1);
        sweep(4096, -1, 5, 0);
        sweep(4096, -1, -1, 0);

        sel = 1'b1;
        sweep(4, -1, -1, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) tbl[i] = 3'($urandom_range(0, 7));
            sel = 1'b0;
            sweep(4096, -1, -1, 1);
            sel = 1'b1;
            sweep(4, -1, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
